// File: rtl/ram_sp_arbiter.sv
// Two-port arbiter in front of one single-port synchronous RAM.
// Round-robin with an optional bounded burst lock for the last-granted port.
module ram_sp_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic                  a_lock,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic                  b_lock,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  output logic                  ram_oe,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } ptr_e;

  ptr_e          ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          a_rv_q, a_rv_d;
  logic          b_rv_q, b_rv_d;
  logic          cnt_ok;

  assign cnt_ok = cnt_q < CW'(MAX_BURST);

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      unique case (1'b1)
        a_req && !b_req: a_gnt = 1'b1;
        b_req && !a_req: b_gnt = 1'b1;
        a_req && b_req: begin
          // Pointed port keeps the RAM only while locked and under budget
          if (ptr_q == PTR_A) begin
            if (a_lock && cnt_ok) a_gnt = 1'b1;
            else                  b_gnt = 1'b1;
          end else begin
            if (b_lock && cnt_ok) b_gnt = 1'b1;
            else                  a_gnt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = '0;
    a_rv_d = a_gnt & ~a_we;
    b_rv_d = b_gnt & ~b_we;
    if (a_gnt || b_gnt) begin
      ptr_d = a_gnt ? PTR_A : PTR_B;
      if (ptr_d == ptr_q) cnt_d = cnt_ok ? cnt_q + CW'(1) : cnt_q;
      else                cnt_d = CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= PTR_B;
      cnt_q  <= '0;
      a_rv_q <= 1'b0;
      b_rv_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      a_rv_q <= a_rv_d;
      b_rv_q <= b_rv_d;
    end
  end

  assign ram_addr = b_gnt ? b_addr : a_addr;
  assign ram_din  = b_gnt ? b_din  : a_din;
  assign ram_we   = (a_gnt & a_we)  | (b_gnt & b_we);
  assign ram_oe   = (a_gnt & ~a_we) | (b_gnt & ~b_we);

  assign a_rvalid = a_rv_q & ~rst;
  assign b_rvalid = b_rv_q & ~rst;
  assign a_rdata  = ram_dout;
  assign b_rdata  = ram_dout;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Directed bench for ram_sp_arbiter with a behavioural
// single-port synchronous RAM behind it.
module tb_ram_sp_arbiter;

  localparam int DW = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, a_lock;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_din;
  logic          a_gnt, a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          b_req, b_we, b_lock;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_din;
  logic          b_gnt, b_rvalid;
  logic [DW-1:0] b_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we, ram_oe;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem [2**AW];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_sp_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MAX_BURST (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a_req   (a_req),
    .a_we    (a_we),
    .a_lock  (a_lock),
    .a_addr  (a_addr),
    .a_din   (a_din),
    .a_gnt   (a_gnt),
    .a_rvalid(a_rvalid),
    .a_rdata (a_rdata),
    .b_req   (b_req),
    .b_we    (b_we),
    .b_lock  (b_lock),
    .b_addr  (b_addr),
    .b_din   (b_din),
    .b_gnt   (b_gnt),
    .b_rvalid(b_rvalid),
    .b_rdata (b_rdata),
    .ram_addr(ram_addr),
    .ram_din (ram_din),
    .ram_we  (ram_we),
    .ram_oe  (ram_oe),
    .ram_dout(ram_dout)
  );

  always @(posedge clk) begin
    if (ram_we)      mem[ram_addr] <= ram_din;
    else if (ram_oe) ram_dout      <= mem[ram_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle_all;
    a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_din = '0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_din = '0;
  endtask

  task automatic do_reset;
    idle_all();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  logic [9:0] pat;

  initial begin
    idle_all();
    ram_dout = '0;
    rst = 1;
    a_req = 1;
    settle();
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_oe", ram_oe, 0);
    tick();
    chk("rst_a_rvalid", a_rvalid, 0);
    do_reset();

    // write then read same address
    a_req = 1; a_we = 1; a_addr = 3; a_din = 4'hA;
    settle();
    chk("wr_gnt", a_gnt, 1);
    chk("wr_we", ram_we, 1);
    chk("wr_addr", ram_addr, 3);
    tick();
    a_we = 0;
    settle();
    chk("rd_gnt", a_gnt, 1);
    chk("rd_oe", ram_oe, 1);
    chk("wr_no_rvalid", a_rvalid, 0);
    tick();
    a_req = 0;
    settle();
    chk("rd_rvalid", a_rvalid, 1);
    chk("rd_data", a_rdata, 4'hA);
    chk("idle_we", ram_we, 0);
    chk("idle_oe", ram_oe, 0);
    tick();
    chk("rd_rvalid_off", a_rvalid, 0);

    // contention without lock alternates A,B,...
    do_reset();
    a_req = 1; b_req = 1;
    pat = 10'b0000001010;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("rr_a%0d", i), a_gnt, !pat[i]);
      chk($sformatf("rr_b%0d", i), b_gnt, pat[i]);
      tick();
    end

    // locked burst from A: AAAAB AAAAB
    do_reset();
    a_req = 1; a_lock = 1; b_req = 1;
    pat = 10'b1000010000;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk($sformatf("lk_a%0d", i), a_gnt, !pat[i]);
      chk($sformatf("lk_b%0d", i), b_gnt, pat[i]);
      tick();
    end

    // mixed simultaneous reads
    do_reset();
    a_req = 1; a_we = 1; a_addr = 5; a_din = 4'h7;
    tick();
    a_addr = 6; a_din = 4'h2;
    tick();
    do_reset();
    a_req = 1; a_addr = 5; b_req = 1; b_addr = 6;
    settle();
    chk("mx_a_gnt", a_gnt, 1);
    chk("mx_b_gnt0", b_gnt, 0);
    tick();
    a_req = 0;
    settle();
    chk("mx_b_gnt", b_gnt, 1);
    chk("mx_a_rvalid", a_rvalid, 1);
    chk("mx_a_rdata", a_rdata, 4'h7);
    chk("mx_b_rv_early", b_rvalid, 0);
    tick();
    b_req = 0;
    settle();
    chk("mx_b_rvalid", b_rvalid, 1);
    chk("mx_b_rdata", b_rdata, 4'h2);
    chk("mx_a_rv_late", a_rvalid, 0);
    tick();
    chk("mx_a_quiet", a_rvalid, 0);
    chk("mx_b_quiet", b_rvalid, 0);

    // reset right after a B read grant
    do_reset();
    a_req = 1; b_req = 1;
    tick();
    settle();
    chk("rm_b_gnt", b_gnt, 1);
    tick();
    rst = 1;
    settle();
    chk("rm_b_rvalid", b_rvalid, 0);
    chk("rm_a_gnt", a_gnt, 0);
    chk("rm_b_gnt0", b_gnt, 0);
    tick();
    rst = 0;
    settle();
    chk("rm_a_first", a_gnt, 1);
    chk("rm_b_after", b_gnt, 0);
    tick();
    idle_all();

    // B cancels while A holds a locked grant
    do_reset();
    a_req = 1; a_we = 1; a_addr = 9; a_din = 4'h3;
    tick();
    a_we = 0; a_lock = 1; a_addr = 1;
    b_req = 1; b_we = 1; b_addr = 9; b_din = 4'hF;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk($sformatf("cx_b_gnt%0d", i), b_gnt, 0);
      tick();
    end
    b_req = 0;
    settle();
    chk("cx_b_gnt2", b_gnt, 0);
    a_addr = 9;
    tick();
    a_req = 0;
    settle();
    chk("cx_mem9", a_rdata, 4'h3);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
